// File: rtl/speed_digit_scheduler.sv
// Speed digit scheduler: converts a binary speed to BCD, commits the digits at frame start,
// and steers one glyph renderer across NDIG slots. Define SPEED_SCHED_LZB_EN for leading-zero blanking.
module speed_digit_scheduler #(
    parameter int IN_W    = 8,
    parameter int NDIG    = 3,
    parameter int BASE_X  = 20,
    parameter int BASE_Y  = 20,
    parameter int GLYPH_W = 18,
    parameter int GLYPH_H = 30,
    parameter int GAP     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [12:0]      i_H_Cont,
    input  logic [12:0]      i_V_Cont,
    input  logic [IN_W-1:0]  i_speed_bin,
    input  logic             i_speed_vld,
    output logic             o_busy,
    output logic             o_digit_en,
    output logic [12:0]      o_digit_x,
    output logic [12:0]      o_digit_y,
    output logic [3:0]       o_digit_val
);

    // Enough BCD digits for any IN_W-bit value, and at least NDIG.
    localparam int BCD_N = ((IN_W + 2) / 3 > NDIG) ? (IN_W + 2) / 3 : NDIG;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IN_W-1:0]      bin_q, bin_d;
    logic [4*BCD_N-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IN_W-1:0]      hold_q, hold_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [3:0]           pend_q [NDIG];
    logic [3:0]           pend_d [NDIG];
    logic                 pend_vld_q, pend_vld_d;
    logic [3:0]           comm_q [NDIG];
    logic [3:0]           comm_d [NDIG];
    logic                 ovf;
    logic                 frame_strobe;
    logic                 v_hit;
    logic [12:0]          slot_org;
`ifdef SPEED_SCHED_LZB_EN
    logic                 lead_zero;
`endif

    function automatic logic [4*BCD_N-1:0] dabble_adj(input logic [4*BCD_N-1:0] b);
        logic [4*BCD_N-1:0] r;
        r = b;
        for (int i = 0; i < BCD_N; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign frame_strobe = (i_H_Cont == 13'd0) && (i_V_Cont == 13'd0);
    assign o_busy       = (state_q == S_SHIFT);

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        comm_d     = comm_q;
        ovf        = 1'b0;

        // Commit uses the registered pending flag, so a DONE in the strobe cycle waits a frame.
        if (frame_strobe && pend_vld_q) begin
            comm_d     = pend_q;
            pend_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_speed_vld || hold_vld_q) begin
                    bin_d      = i_speed_vld ? i_speed_bin : hold_q;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    hold_vld_d = 1'b0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_speed_vld) begin
                    hold_d     = i_speed_bin;
                    hold_vld_d = 1'b1;
                end
                {bcd_d, bin_d} = {dabble_adj(bcd_q), bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_W - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (i_speed_vld) begin
                    hold_d     = i_speed_bin;
                    hold_vld_d = 1'b1;
                end
                for (int i = NDIG; i < BCD_N; i++) begin
                    if (bcd_q[4*i +: 4] != 4'd0) ovf = 1'b1;
                end
                for (int k = 0; k < NDIG; k++) begin
                    pend_d[k] = ovf ? 4'd9 : bcd_q[4*(NDIG-1-k) +: 4];
                end
                pend_vld_d = 1'b1;
                if (hold_vld_q) begin
                    bin_d      = hold_q;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    hold_vld_d = i_speed_vld;
                    state_d    = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hold_vld_q <= 1'b0;
            pend_vld_q <= 1'b0;
            for (int k = 0; k < NDIG; k++) begin
                pend_q[k] <= 4'd0;
                comm_q[k] <= 4'd0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_vld_q <= hold_vld_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            comm_q     <= comm_d;
        end
    end

    always_ff @(posedge i_clk) begin
        bin_q  <= bin_d;
        bcd_q  <= bcd_d;
        hold_q <= hold_d;
    end

    assign v_hit = (i_V_Cont >= 13'(BASE_Y)) && (i_V_Cont < 13'(BASE_Y + GLYPH_H));

    // Slots never overlap, so at most one iteration matches.
    always_comb begin
        o_digit_en  = 1'b0;
        o_digit_x   = 13'(BASE_X);
        o_digit_y   = 13'(BASE_Y);
        o_digit_val = 4'd0;
        slot_org    = 13'(BASE_X);
`ifdef SPEED_SCHED_LZB_EN
        lead_zero   = 1'b1;
`endif
        for (int k = 0; k < NDIG; k++) begin
            slot_org = 13'(BASE_X + k * (GLYPH_W + GAP));
`ifdef SPEED_SCHED_LZB_EN
            lead_zero = lead_zero && (comm_q[k] == 4'd0);
`endif
            if (v_hit && (i_H_Cont >= slot_org) && (i_H_Cont < slot_org + 13'(GLYPH_W))) begin
                o_digit_x   = slot_org;
                o_digit_val = comm_q[k];
`ifdef SPEED_SCHED_LZB_EN
                o_digit_en  = i_en && !(lead_zero && (k < NDIG - 1));
`else
                o_digit_en  = i_en;
`endif
            end
        end
    end

endmodule
